// File: rtl/serial_pkg.sv
// Shared definitions for the valid-framed serial link (transmitter and receiver).
// Optional feature macro: SERIAL_TX_PARITY_EN appends one even-parity beat per frame.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01,
      DONE = 2'b10
   } tx_state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Both ends of the link derive the frame length here so they cannot disagree.
   function automatic int frame_len(input int width);
`ifdef SERIAL_TX_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

endpackage

// File: rtl/serial_tx_bit_counter.sv
// Beat counter for one serial frame; flags the last beat of the frame.
module tx_bit_counter
   import serial_pkg::*;
#(
   parameter int FRAME_LEN = frame_len(DEFAULT_WIDTH),
   parameter int CW        = $clog2(FRAME_LEN + 1)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          clear,
   input  logic          enable,
   output logic [CW-1:0] count,
   output logic          last
);

   // Count beats while sending; width holds FRAME_LEN so the step after the last beat cannot wrap.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + CW'(1);
   end

   assign last = (count == CW'(FRAME_LEN - 1));

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: captures a parallel word on tx_start and shifts it out
// LSB-first inside a contiguous serial_valid burst.
// Optional feature macro: SERIAL_TX_PARITY_EN (adds a final even-parity beat).
//
// state | meaning
// IDLE  | waiting for tx_start; counter held clear
// SEND  | one frame beat per cycle on serial_out
// DONE  | one-cycle completion pulse on tx_done
module serial_tx
   import serial_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             tx_start,
   input  logic [WIDTH-1:0] tx_data,
   output logic             tx_busy,
   output logic             tx_done,
   output logic             serial_valid,
   output logic             serial_out
);

   localparam int FRAME_LEN = frame_len(WIDTH);
   localparam int CW        = $clog2(FRAME_LEN + 1);

   tx_state_t        state;
   tx_state_t        next_state;
   logic [WIDTH-1:0] shift_reg;
   logic [CW-1:0]    count;
   logic             last;
   logic             accept;
   logic             data_beat;
   logic             beat_bit;

   assign accept    = (state == IDLE) && tx_start;
   assign data_beat = (count < CW'(WIDTH));

   tx_bit_counter #(
      .FRAME_LEN (FRAME_LEN),
      .CW        (CW)
   ) u_bit_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (state == IDLE),
      .enable  (state == SEND),
      .count   (count),
      .last    (last)
   );

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic; the unused encoding falls back to IDLE.
   always_comb begin
      next_state = IDLE;
      case (state)
         IDLE:    next_state = tx_start ? SEND : IDLE;
         SEND:    next_state = last ? DONE : SEND;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Capture on accept, then shift right zero-filled during the data beats.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         shift_reg <= '0;
      else if (accept)
         shift_reg <= tx_data;
      else if (state == SEND && data_beat)
         shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
   end

`ifdef SERIAL_TX_PARITY_EN
   logic parity;

   // Even parity of the captured word, sent as the beat after the data bits.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         parity <= 1'b0;
      else if (accept)
         parity <= ^tx_data;
   end

   assign beat_bit = data_beat ? shift_reg[0] : parity;
`else
   assign beat_bit = data_beat & shift_reg[0];
`endif

   // Outputs decode only the defined states, so the unused encoding drives all low.
   assign tx_busy      = (state == SEND) || (state == DONE);
   assign serial_valid = (state == SEND);
   assign tx_done      = (state == DONE);
   assign serial_out   = serial_valid & beat_bit;

endmodule
